// File: rtl/div_16x8_seq_if.sv
// ----------------------------------------------------------------------------
// div_16x8_seq_if
//   Handshake bundle for the sequential divider.
//   Request side : in_valid / in_ready carrying dividend and divisor.
//   Response side: out_valid / out_ready carrying quotient, remainder, div0.
//   Modports:
//     master - the requester/consumer (drives operands and out_ready)
//     slave  - the divider itself (drives in_ready and the result)
// ----------------------------------------------------------------------------
interface div_16x8_seq_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div0;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div0
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div0
    );
endinterface

// File: rtl/div_16x8_seq.sv
// ----------------------------------------------------------------------------
// div_16x8_seq
//   Sequential restoring unsigned divider: DW-bit dividend / VW-bit divisor
//   producing a DW-bit quotient and a VW-bit remainder, one quotient bit per
//   clock. A zero divisor short-circuits to an all-ones quotient, the low
//   dividend bits as remainder and the div0 flag.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - div_16x8_seq_if.slave
//              in_valid/in_ready + dividend/divisor   (accepted only in IDLE)
//              out_valid/out_ready + quotient/remainder/div0 (held in DONE)
//
//   Timing: accept edge -> DW BUSY cycles -> DONE (out_valid high in the
//   (DW+1)th cycle after accept); zero divisor goes straight to DONE.
//   All outputs are registered; nothing combinational from inputs to outputs.
//   DW/VW must match the widths of the connected interface instance.
// ----------------------------------------------------------------------------
module div_16x8_seq #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic                clk,
    input  logic                rst,
    div_16x8_seq_if.slave       bus
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One restoring iteration. Returns {P_next (VW+1 bits), Q_next (DW bits)}.
    // T is kept at VW+1 bits: with P < divisor, T can reach 2*divisor-1,
    // which needs one bit more than the divisor itself.
    function automatic logic [VW+DW:0] div_step(
        input logic [VW:0]   p,
        input logic [DW-1:0] q,
        input logic [VW-1:0] d
    );
        logic [VW:0] t;
        logic [VW:0] d_ext;
        t     = {p[VW-1:0], q[DW-1]};
        d_ext = {1'b0, d};
        if (t >= d_ext) begin
            div_step = {t - d_ext, q[DW-2:0], 1'b1};
        end else begin
            div_step = {t, q[DW-2:0], 1'b0};
        end
    endfunction

    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [VW:0]     p_q,         p_d;
    logic [DW-1:0]   q_q,         q_d;
    logic [VW-1:0]   dvs_q,       dvs_d;
    logic [DW-1:0]   quotient_q,  quotient_d;
    logic [VW-1:0]   remainder_q, remainder_d;
    logic            div0_q,      div0_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [VW+DW:0]  step_s;

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            p_q         <= {(VW+1){1'b0}};
            q_q         <= {DW{1'b0}};
            dvs_q       <= {VW{1'b0}};
            quotient_q  <= {DW{1'b0}};
            remainder_q <= {VW{1'b0}};
            div0_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div0_q      <= div0_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, iteration datapath and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div0_d      = div0_q;
        step_s      = div_step(p_q, q_q, dvs_q);

        case (state_q)
            IDLE: begin
                // in_ready_q is high exactly in IDLE, so in_valid alone
                // qualifies the accept here.
                if (bus.in_valid) begin
                    dvs_d = bus.divisor;
                    if (bus.divisor != {VW{1'b0}}) begin
                        state_d = BUSY;
                        cnt_d   = CW'(DW - 1);
                        p_d     = {(VW+1){1'b0}};
                        q_d     = bus.dividend;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = {DW{1'b1}};
                        remainder_d = bus.dividend[VW-1:0];
                        div0_d      = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                p_d = step_s[VW+DW:DW];
                q_d = step_s[DW-1:0];
                if (cnt_q == {CW{1'b0}}) begin
                    // Last iteration: publish the result straight from the
                    // step so DONE sees it on its first cycle.
                    state_d     = DONE;
                    quotient_d  = step_s[DW-1:0];
                    remainder_d = step_s[VW+DW-1:DW];
                    div0_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div0      = div0_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
module tb_div_16x8_seq;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        d0;
    } res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   rnd_rdy;
    res_t sb[$];

    div_16x8_seq_if #(.DW(16), .VW(8)) bus ();

    div_16x8_seq #(.DW(16), .VW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: plain integer division.
    function automatic res_t golden(input logic [15:0] a, input logic [7:0] b);
        res_t e;
        if (b == 8'd0) begin
            e.q  = 16'hFFFF;
            e.r  = a[7:0];
            e.d0 = 1'b1;
        end else begin
            e.q  = a / {8'd0, b};
            e.r  = 8'(a % {8'd0, b});
            e.d0 = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(golden(bus.dividend, bus.divisor));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("quotient",  32'(bus.quotient),  32'(e.q));
                    chk("remainder", 32'(bus.remainder), 32'(e.r));
                    chk("div0",      32'(bus.div0),      32'(e.d0));
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present an operation and hold it until the accepting edge.
    task automatic send(input logic [15:0] a, input logic [7:0] b);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 200), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    // Count cycles after the accept edge until out_valid is seen.
    task automatic expect_latency(input string tag, input int exp_lat);
        int lat = 0;
        bit seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) seen = 1'b1;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
        tick();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin
            tick();
            n++;
        end
        chk("drain", 32'(n < 300), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rnd_rdy       = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = 16'd0;
        bus.divisor   = 8'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_quotient",  32'(bus.quotient),  32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_div0",      32'(bus.div0),      32'd0);
        rst = 1'b0;
        tick();

        // 1000/7 with latency and literal result checks.
        send(16'd1000, 8'd7);
        begin
            int lat = 0;
            bit seen = 1'b0;
            while (!seen && lat < 40) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid) seen = 1'b1;
            end
            chk("lat_1000_7", 32'(lat), 32'd17);
            chk("q_1000_7",   32'(bus.quotient),  32'd142);
            chk("r_1000_7",   32'(bus.remainder), 32'd6);
            chk("d0_1000_7",  32'(bus.div0),      32'd0);
            tick();
        end
        wait_drain();

        send(16'd65535, 8'd1);   wait_drain();
        send(16'd65535, 8'd255); wait_drain();
        send(16'd5,     8'd9);   wait_drain();
        send(16'd255,   8'd255); wait_drain();

        // Zero divisor: one-cycle latency, then a normal op clears div0.
        send(16'd1234, 8'd0);
        expect_latency("lat_div0", 1);
        wait_drain();
        chk("div0_rem_literal", 32'(bus.remainder), 32'h0000_00D2);
        send(16'd255, 8'd255);   wait_drain();
        chk("div0_cleared", 32'(bus.div0), 32'd0);

        // Backpressure: result held, in_ready low, new requests ignored.
        bus.out_ready = 1'b0;
        send(16'd50000, 8'd13);
        begin
            int n = 0;
            while (!bus.out_valid && n < 40) begin
                tick();
                n++;
            end
        end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 16'(i * 77 + 3);
            bus.divisor  = 8'(i + 1);
            @(negedge clk);
            chk("bp_q",         32'(bus.quotient),  32'd3846);
            chk("bp_r",         32'(bus.remainder), 32'd2);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("ov_drop", 32'(bus.out_valid), 32'd0);
        chk("q_hold",  32'(bus.quotient),  32'd3846);
        chk("sb_empty_bp", 32'(sb.size()), 32'd0);
        tick();

        // Reset in the middle of BUSY aborts the operation.
        send(16'd1000, 8'd7);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk("mid_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_quotient",  32'(bus.quotient),  32'd0);
        chk("mid_remainder", 32'(bus.remainder), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(16'd100, 8'd3);     wait_drain();
        chk("post_rst_q", 32'(bus.quotient), 32'd33);

        // Random ops with random gaps and random out_ready.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            send(a, b);
        end
        rnd_rdy       = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
